// File: rtl/checked_adder_pipe_pkg.sv
// Shared types for the checked add/subtract pipeline: opcode, per-beat flags
// and a width-generic stage payload.
package arith_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic ovf;
        logic eq;
        logic lt;
    } flags_t;

    localparam int unsigned FLAGS_W = $bits(flags_t);

endpackage

// Stage payload for a given operand width; expands to a packed struct type.
`define ARITH_PAYLOAD_T(PW) struct packed { logic [(PW)-1:0] result; arith_pkg::flags_t flags; }

// File: rtl/checked_adder_pipe_if.sv
// Operand and result handshake channels of checked_adder_pipe.
interface checked_adder_pipe_if #(
    parameter int unsigned W = 8
) ();
    import arith_pkg::*;

    logic         in_valid;
    logic         in_ready;
    op_e          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ovf;
    logic         eq;
    logic         lt;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, ovf, eq, lt
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, ovf, eq, lt
    );

endinterface

// File: rtl/checked_adder_pipe_stage.sv
// One enabled pipeline register carrying a valid bit and an opaque payload.
module arith_pipe_stage #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [PW-1:0] data_i,
    output logic          valid_o,
    output logic [PW-1:0] data_o
);

    logic          valid_q;
    logic [PW-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/checked_adder_pipe.sv
// Pipelined add/subtract with optional saturation, per-beat compare flags and
// saturating event counters with a sticky overflow indicator.
module checked_adder_pipe
    import arith_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2,
    parameter bit          SAT   = 1'b0,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    checked_adder_pipe_if.slave  bus,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     ovf_cnt,
    output logic [CNT_W-1:0]     eq_cnt,
    output logic                 err_sticky
);

    typedef `ARITH_PAYLOAD_T(W) payload_t;
    localparam int unsigned PW = $bits(payload_t);

    logic en_c;
    logic xfer_c;

    // Global stall: every stage moves together whenever the output is free.
    assign en_c         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en_c;
    assign xfer_c       = bus.out_valid && bus.out_ready;

    logic [W:0] raw_c;
    payload_t   calc_c;

    always_comb begin
        if (bus.op == OP_SUB) raw_c = {1'b0, bus.a} - {1'b0, bus.b};
        else                  raw_c = {1'b0, bus.a} + {1'b0, bus.b};
        calc_c.flags.ovf = raw_c[W];
        calc_c.flags.eq  = (bus.a == bus.b);
        calc_c.flags.lt  = (bus.a < bus.b);
        calc_c.result    = raw_c[W-1:0];
        if (SAT && raw_c[W]) calc_c.result = (bus.op == OP_SUB) ? '0 : '1;
    end

    logic     s0_vld_q;
    payload_t s0_pay_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld_q <= 1'b0;
            s0_pay_q <= '0;
        end else if (en_c) begin
            s0_vld_q <= bus.in_valid;
            s0_pay_q <= calc_c;
        end
    end

    logic     [DEPTH-1:0] vld_w;
    payload_t [DEPTH-1:0] pay_w;

    assign vld_w[0] = s0_vld_q;
    assign pay_w[0] = s0_pay_q;

    for (genvar i = 1; i < DEPTH; i++) begin : g_stage
        arith_pipe_stage #(.PW(PW)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (en_c),
            .valid_i (vld_w[i-1]),
            .data_i  (pay_w[i-1]),
            .valid_o (vld_w[i]),
            .data_o  (pay_w[i])
        );
    end

    payload_t out_p;
    assign out_p         = pay_w[DEPTH-1];
    assign bus.out_valid = vld_w[DEPTH-1];
    assign bus.result    = out_p.result;
    assign bus.ovf       = out_p.flags.ovf;
    assign bus.eq        = out_p.flags.eq;
    assign bus.lt        = out_p.flags.lt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic             err_q, err_d;

    // Clear wins over a same-cycle event, which is then lost.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        eq_cnt_d  = eq_cnt_q;
        err_d     = err_q;
        if (clr_cnt) begin
            ovf_cnt_d = '0;
            eq_cnt_d  = '0;
            err_d     = 1'b0;
        end else if (xfer_c) begin
            if (out_p.flags.ovf) begin
                ovf_cnt_d = sat_inc(ovf_cnt_q);
                err_d     = 1'b1;
            end
            if (out_p.flags.eq) eq_cnt_d = sat_inc(eq_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
            eq_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            eq_cnt_q  <= eq_cnt_d;
            err_q     <= err_d;
        end
    end

    assign ovf_cnt    = ovf_cnt_q;
    assign eq_cnt     = eq_cnt_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_checked_adder_pipe.sv
// Scoreboard bench: a wrapping DUT with 2-bit counters and a saturating DUT
// with 16-bit counters see identical operand streams.
module tb_checked_adder_pipe;
    import arith_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_cnt;
    logic [1:0]  ovf_cnt0, eq_cnt0;
    logic [15:0] ovf_cnt1, eq_cnt1;
    logic        err0, err1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    checked_adder_pipe_if #(.W(8)) bus0 ();
    checked_adder_pipe_if #(.W(8)) bus1 ();

    checked_adder_pipe #(.W(8), .DEPTH(DEPTH), .SAT(1'b0), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .clr_cnt(clr_cnt),
        .ovf_cnt(ovf_cnt0), .eq_cnt(eq_cnt0), .err_sticky(err0)
    );

    checked_adder_pipe #(.W(8), .DEPTH(DEPTH), .SAT(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .clr_cnt(clr_cnt),
        .ovf_cnt(ovf_cnt1), .eq_cnt(eq_cnt1), .err_sticky(err1)
    );

    typedef struct {
        logic [7:0] a, b;
        op_e        op;
        logic [7:0] wrap, sat;
        logic       ovf, eq, lt;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       ovf, eq, lt;
        int         acc;
        bit         lat;
    } exp_t;

    vec_t tbl [10];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t m0, m1;

    function automatic vec_t mk(input int a, input int b, input op_e op, input int w,
                                input int s, input bit o, input bit e, input bit l);
        vec_t v;
        v.a = 8'(a); v.b = 8'(b); v.op = op; v.wrap = 8'(w); v.sat = 8'(s);
        v.ovf = o; v.eq = e; v.lt = l;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic cnt_chk(input int o0, input int e0, input int o1, input int e1, input bit er);
        chk("d0_ovf_cnt", 32'(ovf_cnt0), 32'(o0));
        chk("d0_eq_cnt",  32'(eq_cnt0),  32'(e0));
        chk("d1_ovf_cnt", 32'(ovf_cnt1), 32'(o1));
        chk("d1_eq_cnt",  32'(eq_cnt1),  32'(e1));
        chk("d0_err_sticky", 32'(err0), 32'(er));
        chk("d1_err_sticky", 32'(err1), 32'(er));
    endtask

    task automatic drive(input bit v, input int i);
        bus0.in_valid = v;         bus1.in_valid = v;
        bus0.a  = tbl[i].a;        bus1.a  = tbl[i].a;
        bus0.b  = tbl[i].b;        bus1.b  = tbl[i].b;
        bus0.op = tbl[i].op;       bus1.op = tbl[i].op;
    endtask

    task automatic set_ready(input bit r);
        bus0.out_ready = r;
        bus1.out_ready = r;
    endtask

    // Present vector i and record expected results at the accepting edge.
    task automatic send(input int i, input bit lat);
        exp_t e0, e1;
        drive(1'b1, i);
        e0 = '{tbl[i].wrap, tbl[i].ovf, tbl[i].eq, tbl[i].lt, 0, lat};
        e1 = '{tbl[i].sat,  tbl[i].ovf, tbl[i].eq, tbl[i].lt, 0, lat};
        for (int n = 0; n <= 50; n++) begin
            @(negedge clk);
            e0.acc = cyc;
            e1.acc = cyc;
            if (bus1.in_ready) q1.push_back(e1);
            if (bus0.in_ready) begin
                q0.push_back(e0);
                break;
            end
            if (n == 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout got in_ready=0 required=1");
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d0_extra_beat got result=%0d required=no beat", bus0.result);
            end else begin
                m0 = q0.pop_front();
                chk("d0_result", 32'(bus0.result), 32'(m0.res));
                chk("d0_ovf", 32'(bus0.ovf), 32'(m0.ovf));
                chk("d0_eq",  32'(bus0.eq),  32'(m0.eq));
                chk("d0_lt",  32'(bus0.lt),  32'(m0.lt));
                if (m0.lat) chk("d0_latency", 32'(cyc - m0.acc), 32'(DEPTH));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d1_extra_beat got result=%0d required=no beat", bus1.result);
            end else begin
                m1 = q1.pop_front();
                chk("d1_result", 32'(bus1.result), 32'(m1.res));
                chk("d1_ovf", 32'(bus1.ovf), 32'(m1.ovf));
                chk("d1_eq",  32'(bus1.eq),  32'(m1.eq));
                chk("d1_lt",  32'(bus1.lt),  32'(m1.lt));
                if (m1.lat) chk("d1_latency", 32'(cyc - m1.acc), 32'(DEPTH));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = mk(3,   5,   OP_ADD, 8,   8,   1'b0, 1'b0, 1'b1);
        tbl[1] = mk(200, 100, OP_ADD, 44,  255, 1'b1, 1'b0, 1'b0);
        tbl[2] = mk(5,   3,   OP_SUB, 2,   2,   1'b0, 1'b0, 1'b0);
        tbl[3] = mk(255, 1,   OP_ADD, 0,   255, 1'b1, 1'b0, 1'b0);
        tbl[4] = mk(0,   1,   OP_SUB, 255, 0,   1'b1, 1'b0, 1'b1);
        tbl[5] = mk(255, 0,   OP_ADD, 255, 255, 1'b0, 1'b0, 1'b0);
        tbl[6] = mk(7,   7,   OP_ADD, 14,  14,  1'b0, 1'b1, 1'b0);
        tbl[7] = mk(9,   9,   OP_SUB, 0,   0,   1'b0, 1'b1, 1'b0);
        tbl[8] = mk(10,  20,  OP_SUB, 246, 0,   1'b1, 1'b0, 1'b1);
        tbl[9] = mk(128, 128, OP_ADD, 0,   255, 1'b1, 1'b1, 1'b0);

        rst_n   = 1'b0;
        clr_cnt = 1'b0;
        set_ready(1'b1);
        drive(1'b0, 0);

        // Values while reset is held.
        #2;
        chk("rst_d0_in_ready",  32'(bus0.in_ready),  32'd1);
        chk("rst_d1_in_ready",  32'(bus1.in_ready),  32'd1);
        chk("rst_d0_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_d1_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_d0_result",    32'(bus0.result),    32'd0);
        chk("rst_d1_result",    32'(bus1.result),    32'd0);
        cnt_chk(0, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Unstalled stream with latency checks.
        send(0, 1'b1); send(1, 1'b1); send(2, 1'b1);
        idle(5);
        cnt_chk(1, 0, 1, 0, 1'b1);
        clr_pulse();
        cnt_chk(0, 0, 0, 0, 1'b0);

        // Boundary operands: wrap versus clamp.
        send(3, 1'b1); send(4, 1'b1);
        idle(5);
        cnt_chk(2, 0, 2, 0, 1'b1);
        send(5, 1'b1); send(8, 1'b1);
        idle(5);
        cnt_chk(3, 0, 3, 0, 1'b1);

        // Backpressure: fill the pipe, hold the output for five cycles.
        set_ready(1'b0);
        send(0, 1'b0); send(2, 1'b0);
        drive(1'b1, 6);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_d0_out_valid", 32'(bus0.out_valid), 32'd1);
            chk("stall_d0_in_ready",  32'(bus0.in_ready),  32'd0);
            chk("stall_d0_result",    32'(bus0.result),    32'(tbl[0].wrap));
            chk("stall_d1_in_ready",  32'(bus1.in_ready),  32'd0);
            chk("stall_d1_result",    32'(bus1.result),    32'(tbl[0].sat));
        end
        @(posedge clk);
        #1;
        set_ready(1'b1);
        send(6, 1'b0); send(7, 1'b0); send(1, 1'b0);
        idle(5);
        cnt_chk(3, 2, 4, 2, 1'b1);

        // Counter saturation, then clear colliding with an eq transfer.
        clr_pulse();
        send(6, 1'b0); send(7, 1'b0); send(9, 1'b0); send(6, 1'b0); send(7, 1'b0);
        idle(5);
        cnt_chk(1, 3, 1, 5, 1'b1);
        send(6, 1'b0);
        drive(1'b0, 0);
        @(posedge clk);
        #1;
        clr_cnt = 1'b1;
        @(negedge clk);
        chk("clr_xfer_d0_out_valid", 32'(bus0.out_valid && bus0.out_ready), 32'd1);
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        cnt_chk(0, 0, 0, 0, 1'b0);
        idle(3);
        cnt_chk(0, 0, 0, 0, 1'b0);

        // Asynchronous reset between edges with beats in flight.
        send(9, 1'b0); send(1, 1'b0); send(2, 1'b0);
        drive(1'b0, 0);
        cnt_chk(1, 1, 1, 1, 1'b1);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("arst_d0_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("arst_d1_out_valid", 32'(bus1.out_valid), 32'd0);
        cnt_chk(0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(0, 1'b1);
        idle(5);
        chk("final_d0_queue_empty", 32'(q0.size()), 32'd0);
        chk("final_d1_queue_empty", 32'(q1.size()), 32'd0);
        cnt_chk(0, 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
